// File: rtl/xor_byte_loader.sv
// Byte-wide valid/ready front-end that serializes fixed-length key/message frames MSB-first
// and raises the matching load flag for each emitted bit.
module xor_byte_loader #(
    parameter int unsigned KEY_BYTES = 4,
    parameter int unsigned MSG_BYTES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [7:0]                   iByte,
    input  logic                         iByte_valid,
    input  logic                         iByte_is_key,
    output logic                         oByte_ready,
    output logic                         oSerial_out,
    output logic                         oLoad_key,
    output logic                         oLoad_msg,
    output logic [$clog2(MSG_BYTES):0]   oByte_count,
    output logic                         oKey_done,
    output logic                         oMsg_done,
    output logic                         oBusy
);

    localparam int unsigned CntW = $clog2(MSG_BYTES) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StWait,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_q, bit_d;
    logic            is_key_q, is_key_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;

    logic            accept;
    logic [CntW-1:0] len_q, len_d;

    assign accept = iByte_valid & ready_q & ena;
    assign len_q  = is_key_q ? CntW'(KEY_BYTES) : CntW'(MSG_BYTES);
    assign len_d  = is_key_d ? CntW'(KEY_BYTES) : CntW'(MSG_BYTES);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        is_key_d = is_key_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;

        if (ena) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        is_key_d = iByte_is_key;
                        shift_d  = iByte;
                        bit_d    = 3'd7;
                        cnt_d    = cnt_q + CntW'(1);
                        state_d  = StShift;
                    end
                end
                StShift: begin
                    if (bit_q != 3'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                    end else if (accept) begin
                        // Reload on the bit-0 cycle keeps the flag window contiguous.
                        shift_d = iByte;
                        bit_d   = 3'd7;
                        cnt_d   = cnt_q + CntW'(1);
                    end else if (cnt_q == len_q) begin
                        shift_d = '0;
                        state_d = StDone;
                    end else begin
                        shift_d = '0;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (accept) begin
                        shift_d = iByte;
                        bit_d   = 3'd7;
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StShift;
                    end
                end
                StDone: begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // Ready is computed from next-state values so the output is a plain flop.
            unique case (state_d)
                StIdle, StWait: ready_d = 1'b1;
                StShift:        ready_d = (bit_d == 3'd0) && (cnt_d != len_d);
                default:        ready_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            bit_q    <= 3'd0;
            is_key_q <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            is_key_q <= is_key_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    logic shifting;
    assign shifting    = ena && (state_q == StShift);

    assign oByte_ready = ready_q;
    assign oSerial_out = shifting && shift_q[7];
    assign oLoad_key   = shifting && is_key_q;
    assign oLoad_msg   = shifting && !is_key_q;
    assign oByte_count = cnt_q;
    assign oKey_done   = ena && (state_q == StDone) && is_key_q;
    assign oMsg_done   = ena && (state_q == StDone) && !is_key_q;
    assign oBusy       = (state_q != StIdle);

    a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(oLoad_key && oLoad_msg));
    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (cnt_q <= len_q));
    a_ready_not_in_done: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StDone) |-> !ready_q);

endmodule

// File: tb/tb_xor_byte_loader.sv
// Directed bench for xor_byte_loader: per-scenario tasks check serial stream, flag windows,
// done pulses and byte counts against hand-computed values.
module tb_xor_byte_loader;

    localparam int unsigned KEY_BYTES = 4;
    localparam int unsigned MSG_BYTES = 64;
    localparam int unsigned CW = $clog2(MSG_BYTES) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b1;
    logic [7:0]    iByte = '0;
    logic          iByte_valid = 1'b0;
    logic          iByte_is_key = 1'b0;
    logic          oByte_ready;
    logic          oSerial_out;
    logic          oLoad_key;
    logic          oLoad_msg;
    logic [CW-1:0] oByte_count;
    logic          oKey_done;
    logic          oMsg_done;
    logic          oBusy;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] key_word = 32'hDEADBEEF;

    xor_byte_loader #(
        .KEY_BYTES(KEY_BYTES),
        .MSG_BYTES(MSG_BYTES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .iByte        (iByte),
        .iByte_valid  (iByte_valid),
        .iByte_is_key (iByte_is_key),
        .oByte_ready  (oByte_ready),
        .oSerial_out  (oSerial_out),
        .oLoad_key    (oLoad_key),
        .oLoad_msg    (oLoad_msg),
        .oByte_count  (oByte_count),
        .oKey_done    (oKey_done),
        .oMsg_done    (oMsg_done),
        .oBusy        (oBusy)
    );

    always #5 clk = ~clk;

    // Cumulative observation counters; tests work on deltas.
    int           cyc = 0;
    int           key_bits = 0;
    int           msg_bits = 0;
    int           key_dones = 0;
    int           msg_dones = 0;
    int           gap_cnt = 0;
    int           quiet_err = 0;
    int           frame_start = 0;
    int           key_done_cyc = 0;
    int           done_cnt_val = 0;
    logic [31:0]  key_stream = '0;
    logic [511:0] msg_stream = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (oLoad_key) begin
            key_bits   <= key_bits + 1;
            key_stream <= {key_stream[30:0], oSerial_out};
        end
        if (oLoad_msg) begin
            msg_bits   <= msg_bits + 1;
            msg_stream <= {msg_stream[510:0], oSerial_out};
        end
        if (!oLoad_key && !oLoad_msg && oSerial_out) quiet_err <= quiet_err + 1;
        if (oBusy && !oLoad_key && !oLoad_msg && !oKey_done && !oMsg_done)
            gap_cnt <= gap_cnt + 1;
        if (iByte_valid && oByte_ready && ena && !oBusy) frame_start <= cyc;
        if (oKey_done) begin
            key_dones    <= key_dones + 1;
            key_done_cyc <= cyc;
            done_cnt_val <= int'(oByte_count);
        end
        if (oMsg_done) begin
            msg_dones    <= msg_dones + 1;
            done_cnt_val <= int'(oByte_count);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one byte and holds it until accepted; starts and ends just after a posedge.
    task automatic send_byte(input logic [7:0] b, input logic k);
        bit acc;
        bit ok;
        ok = 1'b0;
        iByte = b;
        iByte_is_key = k;
        iByte_valid = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            acc = oByte_ready && ena;
            @(posedge clk);
            #1;
            if (acc) ok = 1'b1;
        end
        iByte_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %02h not accepted, oByte_ready=%b", b, oByte_ready);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (!oBusy) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s idle_timeout: oBusy=%b expected 0", tag, oBusy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (oByte_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", oByte_ready);
        end
        n_checks++;
        if ({oSerial_out, oLoad_key, oLoad_msg} !== 3'b000) begin
            n_fail++; $display("FAIL reset_serial_flags: got %b expected 000",
                               {oSerial_out, oLoad_key, oLoad_msg});
        end
        n_checks++;
        if ({oKey_done, oMsg_done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_done: got %b expected 00", {oKey_done, oMsg_done});
        end
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", oBusy);
        end
        n_checks++;
        if (oByte_count !== '0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", oByte_count);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_key_back_to_back();
        int kb0 = key_bits;
        int mb0 = msg_bits;
        int kd0 = key_dones;
        int g0 = gap_cnt;
        int q0 = quiet_err;
        for (int i = 0; i < 4; i++) send_byte(key_word[31-8*i -: 8], 1'b1);
        wait_idle("key_b2b");
        n_checks++;
        if (key_bits - kb0 != 32) begin
            n_fail++; $display("FAIL key_b2b_nbits: got %0d expected 32", key_bits - kb0);
        end
        n_checks++;
        if (key_stream !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL key_b2b_stream: got %08h expected deadbeef", key_stream);
        end
        n_checks++;
        if (gap_cnt - g0 != 0) begin
            n_fail++; $display("FAIL key_b2b_gaps: got %0d expected 0", gap_cnt - g0);
        end
        n_checks++;
        if (msg_bits - mb0 != 0) begin
            n_fail++; $display("FAIL key_b2b_msgflag: got %0d expected 0", msg_bits - mb0);
        end
        n_checks++;
        if (key_dones - kd0 != 1) begin
            n_fail++; $display("FAIL key_b2b_done: got %0d expected 1", key_dones - kd0);
        end
        n_checks++;
        if (key_done_cyc - frame_start != 33) begin
            n_fail++; $display("FAIL key_b2b_done_latency: got %0d expected 33",
                               key_done_cyc - frame_start);
        end
        n_checks++;
        if (done_cnt_val != 4) begin
            n_fail++; $display("FAIL key_b2b_peak_count: got %0d expected 4", done_cnt_val);
        end
        n_checks++;
        if (oByte_count !== '0 || oByte_ready !== 1'b1) begin
            n_fail++; $display("FAIL key_b2b_idle: got count %0d ready %b expected 0 1",
                               oByte_count, oByte_ready);
        end
        n_checks++;
        if (quiet_err != q0) begin
            n_fail++; $display("FAIL key_b2b_quiet: got %0d expected %0d", quiet_err, q0);
        end
    endtask

    task automatic test_msg_frame();
        int kb0 = key_bits;
        int mb0 = msg_bits;
        int md0 = msg_dones;
        int g0 = gap_cnt;
        logic [511:0] exp;
        exp = '0;
        for (int i = 0; i < 64; i++) begin
            exp = {exp[503:0], 8'(i)};
            send_byte(8'(i), 1'b0);
        end
        wait_idle("msg");
        n_checks++;
        if (msg_bits - mb0 != 512) begin
            n_fail++; $display("FAIL msg_nbits: got %0d expected 512", msg_bits - mb0);
        end
        n_checks++;
        if (msg_stream !== exp) begin
            n_fail++; $display("FAIL msg_stream: got %h expected %h", msg_stream, exp);
        end
        n_checks++;
        if (gap_cnt - g0 != 0) begin
            n_fail++; $display("FAIL msg_gaps: got %0d expected 0", gap_cnt - g0);
        end
        n_checks++;
        if (key_bits - kb0 != 0) begin
            n_fail++; $display("FAIL msg_keyflag: got %0d expected 0", key_bits - kb0);
        end
        n_checks++;
        if (msg_dones - md0 != 1) begin
            n_fail++; $display("FAIL msg_done: got %0d expected 1", msg_dones - md0);
        end
        n_checks++;
        if (done_cnt_val != 64) begin
            n_fail++; $display("FAIL msg_peak_count: got %0d expected 64", done_cnt_val);
        end
    endtask

    task automatic test_valid_gap();
        int kb0 = key_bits;
        int kd0 = key_dones;
        int g0 = gap_cnt;
        int q0 = quiet_err;
        bit ok;
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (oByte_ready) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL gap_ready_timeout: oByte_ready=%b expected 1", oByte_ready);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        wait_idle("gap");
        n_checks++;
        if (gap_cnt - g0 != 3) begin
            n_fail++; $display("FAIL gap_cycles: got %0d expected 3", gap_cnt - g0);
        end
        n_checks++;
        if (key_bits - kb0 != 32) begin
            n_fail++; $display("FAIL gap_nbits: got %0d expected 32", key_bits - kb0);
        end
        n_checks++;
        if (key_stream !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL gap_stream: got %08h expected deadbeef", key_stream);
        end
        n_checks++;
        if (quiet_err != q0 || key_dones - kd0 != 1) begin
            n_fail++; $display("FAIL gap_quiet_done: got quiet %0d done %0d expected %0d 1",
                               quiet_err, key_dones - kd0, q0);
        end
    endtask

    task automatic test_ena_pause();
        int kb0 = key_bits;
        int kd0 = key_dones;
        int g0 = gap_cnt;
        int q0 = quiet_err;
        send_byte(8'hDE, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ena = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (oBusy !== 1'b1 || oLoad_key !== 1'b0) begin
            n_fail++; $display("FAIL ena_hold: got busy %b load_key %b expected 1 0",
                               oBusy, oLoad_key);
        end
        ena = 1'b1;
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        wait_idle("ena");
        n_checks++;
        if (gap_cnt - g0 != 5) begin
            n_fail++; $display("FAIL ena_gap: got %0d expected 5", gap_cnt - g0);
        end
        n_checks++;
        if (key_bits - kb0 != 32 || key_stream !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL ena_stream: got %0d bits %08h expected 32 deadbeef",
                               key_bits - kb0, key_stream);
        end
        n_checks++;
        if (quiet_err != q0 || key_dones - kd0 != 1) begin
            n_fail++; $display("FAIL ena_quiet_done: got quiet %0d done %0d expected %0d 1",
                               quiet_err, key_dones - kd0, q0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int md0 = msg_dones;
        int kb0;
        int kd0;
        for (int i = 0; i < 30; i++) send_byte(8'hFF - 8'(i), 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (oLoad_msg !== 1'b1 || oSerial_out !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: got load_msg %b serial %b expected 1 1",
                               oLoad_msg, oSerial_out);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({oSerial_out, oLoad_key, oLoad_msg, oBusy} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %b expected 0000",
                               {oSerial_out, oLoad_key, oLoad_msg, oBusy});
        end
        n_checks++;
        if (oByte_count !== '0 || oByte_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_count_ready: got %0d %b expected 0 1",
                               oByte_count, oByte_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (msg_dones != md0) begin
            n_fail++; $display("FAIL rst_mid_no_done: got %0d expected %0d", msg_dones, md0);
        end
        kb0 = key_bits;
        kd0 = key_dones;
        for (int i = 0; i < 4; i++) send_byte(key_word[31-8*i -: 8], 1'b1);
        wait_idle("rst_mid_key");
        n_checks++;
        if (key_bits - kb0 != 32 || key_stream !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rst_mid_key: got %0d bits %08h expected 32 deadbeef",
                               key_bits - kb0, key_stream);
        end
        n_checks++;
        if (key_dones - kd0 != 1) begin
            n_fail++; $display("FAIL rst_mid_key_done: got %0d expected 1", key_dones - kd0);
        end
    endtask

    task automatic test_is_key_ignored();
        int kb0 = key_bits;
        int mb0 = msg_bits;
        int kd0 = key_dones;
        int md0 = msg_dones;
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        wait_idle("is_key");
        n_checks++;
        if (key_bits - kb0 != 32 || msg_bits - mb0 != 0) begin
            n_fail++; $display("FAIL is_key_flags: got key %0d msg %0d expected 32 0",
                               key_bits - kb0, msg_bits - mb0);
        end
        n_checks++;
        if (key_stream !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL is_key_stream: got %08h expected deadbeef", key_stream);
        end
        n_checks++;
        if (key_dones - kd0 != 1 || msg_dones - md0 != 0) begin
            n_fail++; $display("FAIL is_key_done: got key %0d msg %0d expected 1 0",
                               key_dones - kd0, msg_dones - md0);
        end
    endtask

    initial begin
        test_reset();
        test_key_back_to_back();
        test_msg_frame();
        test_valid_gap();
        test_ena_pause();
        test_reset_mid_frame();
        test_is_key_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
